// File: rtl/mips_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline-stage buffers of the MIPS core.
package mips_pipe_pkg;

    localparam logic [5:0] NOP_OPCODE_DEF = 6'd63;
    localparam int         MAX_WIDTH      = 1024;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Opcode in the top six bits, everything else zero; callers truncate to their WIDTH.
    function automatic logic [MAX_WIDTH-1:0] nop_word(input int width, input logic [5:0] opcode);
        logic [MAX_WIDTH-1:0] w;
        w = MAX_WIDTH'(opcode) << (width - 6);
        return w;
    endfunction

endpackage

// File: rtl/pipe_stage_storage.sv
// DEPTH x WIDTH circular buffer with read/write pointers and occupancy count.
module pipe_stage_storage
    import mips_pipe_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] NOP_WORD = '0,
    parameter int               CNT_BITS = clog2(DEPTH + 1)
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    head,
    output logic [CNT_BITS-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths never visit unused indices.
    function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the entries are reset here on purpose so an empty buffer reads back a NOP word,
    // which costs a reset on every storage flop; plain data arrays are normally left unreset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= advance(wr_ptr);
            if (pop)  rd_ptr <= advance(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register: valid/ready handshake, skid buffer,
// flush > stall > bubble control and saturating stall/flush counters.
module pipe_stage_buffer
    import mips_pipe_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter int         DEPTH      = 2,
    parameter logic [5:0] NOP_OPCODE = NOP_OPCODE_DEF,
    parameter int         CNT_W      = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          bubble,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int               CNT_BITS = clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] NOP_WORD = WIDTH'(nop_word(WIDTH, NOP_OPCODE));

    logic             push;
    logic             pop;
    logic             stall_inc;
    logic             flush_inc;
    logic [WIDTH-1:0] head;
    logic             non_empty;

    pipe_stage_storage #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD),
        .CNT_BITS (CNT_BITS)
    ) u_storage (
        .Clk     (Clk),
        .Rst     (Rst),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .wr_data (in_data),
        .head    (head),
        .count   (count)
    );

    assign non_empty = (count != '0);
    // Depends only on registered occupancy and flush, never on out_ready.
    assign in_ready  = (count < CNT_BITS'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        out_valid = non_empty;
        out_data  = non_empty ? head : NOP_WORD;
        pop       = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (flush) begin
            out_valid = 1'b0;
            out_data  = NOP_WORD;
            flush_inc = non_empty;
        end else if (stall) begin
            out_valid = 1'b0;
            stall_inc = non_empty;
        end else if (bubble) begin
            out_valid = 1'b1;
            out_data  = NOP_WORD;
        end else begin
            pop       = out_valid && out_ready;
            stall_inc = out_valid && !out_ready;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: DEPTH=2 instance for control paths, DEPTH=3 for wrap.
module tb_pipe_stage_buffer;

    localparam logic [63:0] NOP = {6'd63, 58'b0};

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;

    logic        a_in_valid = 0, a_out_ready = 0, a_stall = 0, a_flush = 0, a_bubble = 0;
    logic [63:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [1:0]  a_count;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        b_in_valid = 0, b_out_ready = 0;
    logic [63:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [1:0]  b_count;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    pipe_stage_buffer #(.WIDTH(64), .DEPTH(2)) dut_a (
        .Clk(Clk), .Rst(Rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .stall(a_stall), .flush(a_flush), .bubble(a_bubble),
        .count(a_count), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_buffer #(.WIDTH(64), .DEPTH(3)) dut_b (
        .Clk(Clk), .Rst(Rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall(1'b0), .flush(1'b0), .bubble(1'b0),
        .count(b_count), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a settle delay.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int next_push;
        int next_exp;
        int cycles;

        // Reset state
        #12;
        check("rst_count", a_count, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, NOP);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_stall_cnt", a_stall_cnt, 0);
        check("rst_flush_cnt", a_flush_cnt, 0);
        Rst = 1'b1;
        step();

        // Streaming: 1..4 emerge one per cycle, occupancy stays 1
        a_out_ready = 1; a_in_valid = 1; a_in_data = 1;
        settle();
        check("stream_empty_valid", a_out_valid, 0);
        step();
        for (int i = 2; i <= 5; i++) begin
            a_in_data  = 64'(i);
            a_in_valid = (i <= 4);
            settle();
            check("stream_data", a_out_data, 64'(i - 1));
            check("stream_count", a_count, 1);
            check("stream_in_ready", a_in_ready, 1);
            step();
        end
        settle();
        check("stream_drained", a_count, 0);
        check("stream_no_stall", a_stall_cnt, 0);

        // Backpressure
        a_out_ready = 0; a_in_valid = 1; a_in_data = 64'hA;
        step();
        a_in_data = 64'hB;
        settle();
        check("bp_count1", a_count, 1);
        step();
        a_in_valid = 0;
        settle();
        check("bp_full_count", a_count, 2);
        check("bp_full_in_ready", a_in_ready, 0);
        check("bp_stall_cnt1", a_stall_cnt, 1);
        step();
        check("bp_stall_cnt2", a_stall_cnt, 2);
        a_out_ready = 1;
        settle();
        check("bp_pop_a", a_out_data, 64'hA);
        check("bp_pop_a_valid", a_out_valid, 1);
        step();
        check("bp_pop_b", a_out_data, 64'hB);
        step();
        check("bp_empty", a_count, 0);
        check("bp_stall_hold", a_stall_cnt, 2);

        // Flush with two entries
        a_out_ready = 0; a_in_valid = 1; a_in_data = 64'hC;
        step();
        a_in_data = 64'hD;
        step();
        check("fl_pre_count", a_count, 2);
        a_flush = 1; a_in_valid = 1; a_in_data = 64'hE;
        settle();
        check("fl_out_valid", a_out_valid, 0);
        check("fl_in_ready", a_in_ready, 0);
        check("fl_out_data", a_out_data, NOP);
        step();
        a_flush = 0; a_in_valid = 0;
        settle();
        check("fl_count", a_count, 0);
        check("fl_nop", a_out_data, NOP);
        check("fl_cnt1", a_flush_cnt, 1);
        check("fl_stall_cnt", a_stall_cnt, 3);
        a_flush = 1;
        step();
        a_flush = 0;
        settle();
        check("fl_empty_cnt", a_flush_cnt, 1);

        // Bubble keeps the head
        a_in_valid = 1; a_in_data = 64'h5;
        step();
        a_in_valid = 0; a_bubble = 1; a_out_ready = 1;
        settle();
        check("bub_valid", a_out_valid, 1);
        check("bub_nop", a_out_data, NOP);
        step();
        a_bubble = 0;
        settle();
        check("bub_retained_count", a_count, 1);
        check("bub_retained_data", a_out_data, 64'h5);
        step();
        check("bub_popped", a_count, 0);
        a_bubble = 1;
        settle();
        check("bub_empty_valid", a_out_valid, 1);
        check("bub_empty_nop", a_out_data, NOP);
        a_bubble = 0;

        // Flush beats stall and bubble
        a_out_ready = 0; a_in_valid = 1; a_in_data = 64'h6;
        step();
        a_in_valid = 0; a_stall = 1; a_bubble = 1; a_flush = 1;
        settle();
        check("pri_valid", a_out_valid, 0);
        step();
        a_stall = 0; a_bubble = 0; a_flush = 0;
        settle();
        check("pri_count", a_count, 0);
        check("pri_flush_cnt", a_flush_cnt, 2);
        check("pri_stall_cnt", a_stall_cnt, 3);

        // Stall still accepts pushes
        a_in_valid = 1; a_in_data = 64'h7;
        step();
        a_stall = 1; a_in_data = 64'h8; a_out_ready = 1;
        settle();
        check("stl_valid", a_out_valid, 0);
        check("stl_in_ready", a_in_ready, 1);
        step();
        a_stall = 0; a_in_valid = 0; a_out_ready = 0;
        settle();
        check("stl_count", a_count, 2);
        check("stl_stall_cnt", a_stall_cnt, 4);
        check("stl_head", a_out_data, 64'h7);

        // Asynchronous reset between edges
        #2;
        Rst = 0;
        #1;
        check("arst_count", a_count, 0);
        check("arst_valid", a_out_valid, 0);
        check("arst_in_ready", a_in_ready, 1);
        check("arst_stall_cnt", a_stall_cnt, 0);
        check("arst_flush_cnt", a_flush_cnt, 0);
        check("arst_data", a_out_data, NOP);
        #3;
        Rst = 1;
        step();

        // DEPTH=3: fill, check full, then stream 7 items through with wrap
        b_out_ready = 0; b_in_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            b_in_data = 64'(i);
            step();
        end
        b_in_valid = 0;
        settle();
        check("d3_full_count", b_count, 3);
        check("d3_full_in_ready", b_in_ready, 0);
        next_push = 4;
        next_exp  = 1;
        cycles    = 0;
        b_out_ready = 1;
        while ((next_exp <= 7) && (cycles < 40)) begin
            b_in_valid = (next_push <= 7);
            b_in_data  = 64'(next_push);
            settle();
            if (b_out_valid) begin
                check("d3_order", b_out_data, 64'(next_exp));
                next_exp++;
            end
            if (b_in_valid && b_in_ready) next_push++;
            step();
            cycles++;
        end
        b_in_valid = 0;
        settle();
        check("d3_all_out", 64'(next_exp), 64'd8);
        check("d3_final_count", b_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised, elastic pipeline-stage register for the pipelined MIPS core, successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It adds a valid/ready handshake, a configurable-depth skid buffer, and per-stage stall, flush and NOP-bubble control. Built-in saturating performance counters record stall and flush activity. One instance sits between each pair of stages; hazard logic drives stall/flush/bubble.

Parameters:
WIDTH, 64, payload width in bits (>=8).
DEPTH, 2, buffer entries (>=1); DEPTH>=2 gives full throughput.
NOP_OPCODE, 6'd63, opcode placed in payload bits [WIDTH-1:WIDTH-6] for a NOP word; all other bits 0.
CNT_W, 16, width of performance counters.

Ports:
Clk  in  1  clock, rising edge.
Rst  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream presents in_data.
in_ready  out  1  buffer accepts in_data this cycle.
in_data  in  WIDTH  payload from upstream stage.
out_valid  out  1  out_data is valid for downstream.
out_ready  in  1  downstream consumes out_data this cycle.
out_data  out  WIDTH  head entry, or NOP word.
stall  in  1  hold stage: no pop, out_valid forced 0.
flush  in  1  discard all buffered entries.
bubble  in  1  present NOP downstream, keep head entry.
count  out  $clog2(DEPTH+1)  current occupancy.
stall_cnt  out  CNT_W  saturating count of held cycles.
flush_cnt  out  CNT_W  saturating count of flush cycles that discarded >=1 entry.

Behaviour:
- NOP word: {NOP_OPCODE, (WIDTH-6)'b0}.
- Reset (Rst=0, async): count=0, read/write pointers=0, all entries=NOP word, stall_cnt=0, flush_cnt=0. Outputs: out_valid=0, out_data=NOP word, in_ready=1.
- in_ready = (count<DEPTH) && !flush. It is registered-state only and never depends on out_ready.
- push = in_valid && in_ready. It writes at the write pointer, and the pointer advances modulo DEPTH.
- Default out_valid = (count!=0). Default out_data = head entry, or the NOP word when count==0.
- Control priority per cycle: flush > stall > bubble > normal.
- flush=1:
  - out_valid=0 and out_data=NOP word combinationally.
  - No push, no pop.
  - At the edge: count=0 and pointers=0. Entries are not cleared.
  - flush_cnt increments if count!=0.
- stall=1 (no flush):
  - out_valid=0, no pop.
  - Push is still allowed if there is room.
  - stall_cnt increments if count!=0.
- bubble=1 (no flush/stall):
  - out_valid=1 and out_data=NOP word, even when count==0.
  - No pop; the head is retained for the next cycle.
  - Push is still allowed.
- Normal: pop = out_valid && out_ready. The read pointer advances modulo DEPTH. stall_cnt increments when out_valid && !out_ready.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count==DEPTH): in_ready=0, so push never occurs even if pop occurs. DEPTH=1 therefore sustains 50% throughput.
- Empty: pop cannot occur. out_data=NOP word (except bubble as above).
- Latency: data pushed at edge N is visible on out_data after edge N (one cycle, register-to-output). There is no combinational in→out path.
- Order is strict FIFO. Pointer wrap is at DEPTH-1→0 for non-power-of-two DEPTH as well.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-operation: immediate return to reset state, regardless of Clk. Outputs are at reset values while Rst=0.

Decomposition:
- Package mips_pipe_pkg holds:
  - NOP_OPCODE default (6'd63);
  - a function building the NOP word for a given WIDTH;
  - a clog2 helper for count/pointer widths.
- Sub-module pipe_stage_storage: DEPTH×WIDTH circular buffer with pointers and occupancy. It has push/pop inputs and head data/count outputs, and reset-to-NOP entries.
- Top level holds control priority, handshake gating and counters.

Test Plan:
- Reset then DEPTH=2 streaming: in_valid=1 with data 1,2,3,4; out_ready=1 → out_data 1,2,3,4 on consecutive cycles starting one cycle after first push; in_ready stays 1; count stays 1.
- Backpressure: out_ready=0, push 0xA,0xB → count=2, in_ready=0, stall_cnt increments each held cycle. Then out_ready=1 → 0xA then 0xB, count returns to 0.
- Flush with count=2 → that cycle out_valid=0 and in_ready=0. Next cycle count=0, out_data=NOP word {6'd63,0}, flush_cnt=1. Flush when empty leaves flush_cnt unchanged.
- Bubble with head 0x5 and out_ready=1 for one cycle → out_valid=1, out_data=NOP word, 0x5 retained. Next cycle out_data=0x5 and pops.
- Stall+bubble+flush asserted together with count=1 → flush wins: count=0, out_valid=0 that cycle. Stall alone with in_valid=1 still pushes (count 1→2).
- Async reset mid-stream (Rst low between edges) → count=0, out_valid=0, in_ready=1 immediately. Counters 0. DEPTH=3 wrap test: push/pop 7 items in order, no loss.
